imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Pipelined, parametrised immediate decoder for the rv32i core. It sits between fetch and the register-read/execute stage and accepts raw instruction words over a valid/ready handshake. It classifies the immediate format from the opcode itself, so no external format control is needed. It emits a registered, XLEN-wide extended immediate with its format code, tag and illegal flag, and a 2-entry skid buffer sustains one instruction per cycle under backpressure.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAGW, 8, width of the opaque sideband tag (e.g. PC index) carried alongside each instruction.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single output register with in_ready = !out_valid | out_ready.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  in_instr/in_tag valid.
- in_ready  output  1  block can accept this cycle.
- in_instr  input  32  instruction word.
- in_tag  input  TAGW  sideband tag.
- out_valid  output  1  output payload valid.
- out_ready  input  1  consumer accepts this cycle.
- out_imm  output  XLEN  extended immediate.
- out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- out_tag  output  TAGW  tag of the instruction on the output.
- out_illegal  output  1  opcode not recognised.

## Operation
- Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
- Opcode map, using in_instr[6:0]:
  - LOAD 0000011, JALR 1100111 and MISC-MEM 0001111 decode as I.
  - OP-IMM 0010011 decodes as SHAMT when funct3 = 001 or 101, else I.
  - STORE 0100011 decodes as S.
  - BRANCH 1100011 decodes as B.
  - LUI 0110111 and AUIPC 0010111 decode as U.
  - JAL 1101111 decodes as J.
  - OP 0110011 decodes as NONE.
  - SYSTEM 1110011 decodes as I when funct3[2] = 0, else ZIMM (see Configuration).
  - OP-IMM-32 0011011 is recognised only when XLEN = 64: SHAMT (5-bit) for funct3 001/101, else I.
  - Every other opcode gives out_illegal = 1, fmt NONE, imm 0.
- Immediate construction:
  - I, S, B, U and J are sign-extended from instr[31] to XLEN. B and J carry an implicit bit 0 = 0.
  - U is {instr[31:12], 12'b0}, then sign-extended.
  - SHAMT is zero-extended: instr[24:20] when XLEN = 32, or for OP-IMM-32; instr[25:20] for OP-IMM when XLEN = 64.
  - ZIMM is instr[19:15] zero-extended.
  - NONE gives 0.
- Decode is combinational on the input side. Results are registered only in the buffer entries.
- SKID = 1 buffering:
  - The main entry drives the outputs.
  - The skid entry captures an accepted word when the main entry is full and not draining.
  - in_ready is the registered value of !skid_full.
  - Order is strictly FIFO.
- flush clears every valid bit. An input presented in the flush cycle is discarded. rst has priority over flush.

## Timing
- Latency: one cycle from input acceptance to out_valid. Throughput is one per cycle while out_ready = 1.
- Output payload holds stable while out_valid & !out_ready.
- Values after reset: out_valid 0, out_imm 0, out_fmt 0, out_tag 0, out_illegal 0, in_ready 1. The first input is accepted in the cycle after rst deasserts.
- Full buffer (both entries, SKID = 1): in_ready = 0 from the next cycle. A simultaneous in-accept and out-accept when one entry is full leaves occupancy unchanged.
- Flush takes effect at the edge: out_valid = 0 and in_ready = 1 the following cycle.
- rst mid-stream drops all in-flight entries. No partial outputs are produced.

## Configuration
- IMM_DECODE_ZIMM_EN defined: SYSTEM with funct3[2] = 1 gives fmt ZIMM, imm = zero-extended instr[19:15].
- IMM_DECODE_ZIMM_EN undefined: those encodings decode as I, imm = sign-extended instr[31:20]. Code 7 never appears.

## Test plan
- 0xFFF00093 (addi x1,x0,-1), XLEN 32 -> out_imm 0xFFFFFFFF, fmt 1, illegal 0, one cycle later.
- 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, fmt 3. 0x123450B7 (lui) -> imm 0x12345000, fmt 4. 0x4030D093 (srai x1,x1,3) -> imm 3, fmt 6.
- 0x3002D073 (csrrwi): with the macro, imm 5, fmt 7; without it, imm 0x300, fmt 1. 0x0000007F -> illegal 1, imm 0, fmt 0.
- Stream 6 back-to-back words (tags 1..6), out_ready low for cycles 2-4 -> in_ready drops after 2 buffered; all 6 emerge in order, none dropped or duplicated, payload stable while stalled.
- Buffer full, flush asserted with in_valid = 1 -> next cycle out_valid 0, in_ready 1; the flushed-cycle word never appears.
- rst asserted with 2 entries buffered -> all outputs at reset values next cycle; XLEN 64 lui 0x800000B7 -> imm 0xFFFFFFFF80000000.

Source files
------------

// File: rtl/imm_decode_stage.sv
// rv32i immediate decoder stage: opcode-driven format classification, XLEN extension, skid-buffered output.
// Optional IMM_DECODE_ZIMM_EN: SYSTEM with funct3[2]=1 yields ZIMM (fmt 7) instead of I.
module imm_decode_stage #(
    parameter int XLEN = 32,
    parameter int TAGW = 8,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [TAGW-1:0] out_tag,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } immFmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    immFmt_e         decFmt;
    logic            decIll;
    logic [XLEN-1:0] decImm;
    logic            wideShamt;

    assign opcode    = in_instr[6:0];
    assign funct3    = in_instr[14:12];
    assign wideShamt = (XLEN == 64) && (opcode == OP_IMM);

    always_comb begin
        decFmt = FMT_NONE;
        decIll = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR, OP_MISC: decFmt = FMT_I;
            // funct3 001 and 101 are the only encodings with low bits 01
            OP_IMM:                    decFmt = (funct3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
            OP_STORE:                  decFmt = FMT_S;
            OP_BRANCH:                 decFmt = FMT_B;
            OP_LUI, OP_AUIPC:          decFmt = FMT_U;
            OP_JAL:                    decFmt = FMT_J;
            OP_OP:                     decFmt = FMT_NONE;
`ifdef IMM_DECODE_ZIMM_EN
            OP_SYSTEM:                 decFmt = funct3[2] ? FMT_ZIMM : FMT_I;
`else
            OP_SYSTEM:                 decFmt = FMT_I;
`endif
            OP_IMM32: begin
                if (XLEN == 64) decFmt = (funct3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
                else            decIll = 1'b1;
            end
            default:                   decIll = 1'b1;
        endcase
    end

    always_comb begin
        decImm = '0;
        case (decFmt)
            FMT_I:     decImm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
            FMT_S:     decImm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
            FMT_B:     decImm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                        in_instr[30:25], in_instr[11:8], 1'b0});
            FMT_U:     decImm = sext32({in_instr[31:12], 12'b0});
            FMT_J:     decImm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                        in_instr[20], in_instr[30:21], 1'b0});
            FMT_SHAMT: decImm[5:0] = {wideShamt & in_instr[25], in_instr[24:20]};
            FMT_ZIMM:  decImm[4:0] = in_instr[19:15];
            default:   decImm = '0;
        endcase
    end

    logic            mainValid, skidValid, inReadyReg;
    logic [XLEN-1:0] mainImm, skidImm;
    immFmt_e         mainFmt, skidFmt;
    logic [TAGW-1:0] mainTag, skidTag;
    logic            mainIll, skidIll;
    logic            inFire, outFire;

    assign in_ready = (SKID != 0) ? inReadyReg : (!mainValid || out_ready);
    assign inFire   = in_valid && in_ready;
    assign outFire  = mainValid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mainValid  <= 1'b0;
            skidValid  <= 1'b0;
            inReadyReg <= 1'b1;
            mainImm    <= '0;
            mainFmt    <= FMT_NONE;
            mainTag    <= '0;
            mainIll    <= 1'b0;
            skidImm    <= '0;
            skidFmt    <= FMT_NONE;
            skidTag    <= '0;
            skidIll    <= 1'b0;
        end else if (flush) begin
            mainValid  <= 1'b0;
            skidValid  <= 1'b0;
            inReadyReg <= 1'b1;
        end else if (SKID != 0) begin
            // in_ready mirrors an empty skid, so skid refill and input capture never coincide
            if (!mainValid || outFire) begin
                inReadyReg <= 1'b1;
                if (skidValid) begin
                    mainValid <= 1'b1;
                    mainImm   <= skidImm;
                    mainFmt   <= skidFmt;
                    mainTag   <= skidTag;
                    mainIll   <= skidIll;
                    skidValid <= 1'b0;
                end else begin
                    mainValid <= inFire;
                    if (inFire) begin
                        mainImm <= decImm;
                        mainFmt <= decFmt;
                        mainTag <= in_tag;
                        mainIll <= decIll;
                    end
                end
            end else if (inFire) begin
                skidValid  <= 1'b1;
                skidImm    <= decImm;
                skidFmt    <= decFmt;
                skidTag    <= in_tag;
                skidIll    <= decIll;
                inReadyReg <= 1'b0;
            end
        end else begin
            if (inFire) begin
                mainValid <= 1'b1;
                mainImm   <= decImm;
                mainFmt   <= decFmt;
                mainTag   <= in_tag;
                mainIll   <= decIll;
            end else if (outFire) begin
                mainValid <= 1'b0;
            end
        end
    end

    assign out_valid   = mainValid;
    assign out_imm     = mainImm;
    assign out_fmt     = mainFmt;
    assign out_tag     = mainTag;
    assign out_illegal = mainIll;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: arithmetic decode model + FIFO scoreboard, directed vectors at XLEN 32 and 64.
// Expectations follow IMM_DECODE_ZIMM_EN the same way the design does.
module tb_imm_decode_stage;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [7:0]  tag;
        logic        ill;
    } exp_t;

`ifdef IMM_DECODE_ZIMM_EN
    localparam bit ZIMM_ON = 1'b1;
`else
    localparam bit ZIMM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] inInstr = '0;
    logic [7:0]  inTag = '0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] outImm;
    logic [2:0]  outFmt;
    logic [7:0]  outTag;
    logic        outIll;

    logic        flush64 = 1'b0;
    logic        in64Valid = 1'b0;
    logic        in64Ready;
    logic [31:0] in64Instr = '0;
    logic [7:0]  in64Tag = '0;
    logic        out64Valid;
    logic        out64Ready = 1'b1;
    logic [63:0] out64Imm;
    logic [2:0]  out64Fmt;
    logic [7:0]  out64Tag;
    logic        out64Ill;

    int checks = 0;
    int errors = 0;
    int outCount = 0;
    bit seenFlushed = 1'b0;
    bit sawBusy = 1'b0;
    bit stalled = 1'b0;
    logic [31:0] holdImm;
    logic [7:0]  holdTag;
    exp_t q[$];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAGW(8), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_instr(inInstr), .in_tag(inTag),
        .out_valid(outValid), .out_ready(outReady), .out_imm(outImm),
        .out_fmt(outFmt), .out_tag(outTag), .out_illegal(outIll)
    );

    imm_decode_stage #(.XLEN(64), .TAGW(8), .SKID(1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush64),
        .in_valid(in64Valid), .in_ready(in64Ready), .in_instr(in64Instr), .in_tag(in64Tag),
        .out_valid(out64Valid), .out_ready(out64Ready), .out_imm(out64Imm),
        .out_fmt(out64Fmt), .out_tag(out64Tag), .out_illegal(out64Ill)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Immediate values rebuilt as signed integers from the field weights of each format
    function automatic exp_t modelDecode(input logic [31:0] w, input int xlen, input logic [7:0] tag);
        exp_t   e;
        int     f3;
        longint v;
        f3 = int'(w[14:12]);
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.tag = tag;
        v = 0;
        case (w[6:0])
            7'h03, 7'h67, 7'h0F: e.fmt = 3'd1;
            7'h13:               e.fmt = (f3 == 1 || f3 == 5) ? 3'd6 : 3'd1;
            7'h23:               e.fmt = 3'd2;
            7'h63:               e.fmt = 3'd3;
            7'h37, 7'h17:        e.fmt = 3'd4;
            7'h6F:               e.fmt = 3'd5;
            7'h33:               e.fmt = 3'd0;
            7'h73:               e.fmt = (f3 >= 4 && ZIMM_ON) ? 3'd7 : 3'd1;
            7'h1B: begin
                if (xlen == 64) e.fmt = (f3 == 1 || f3 == 5) ? 3'd6 : 3'd1;
                else            e.ill = 1'b1;
            end
            default:             e.ill = 1'b1;
        endcase
        case (e.fmt)
            3'd1: begin
                v = longint'(w[31:20]);
                if (w[31]) v = v - 4096;
            end
            3'd2: begin
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                if (w[31]) v = v - 4096;
            end
            3'd3: begin
                v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                if (w[31]) v = v - 4096;
            end
            3'd4: begin
                v = longint'(w[31:12]) * 4096;
                if (w[31]) v = v - 64'sh1_0000_0000;
            end
            3'd5: begin
                v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                if (w[31]) v = v - 1048576;
            end
            3'd6: v = (xlen == 64 && w[6:0] == 7'h13) ? longint'(w[25:20]) : longint'(w[24:20]);
            3'd7: v = longint'(w[19:15]);
            default: v = 0;
        endcase
        e.imm = v;
        return e;
    endfunction

    // Scoreboard update at each edge, using pre-edge handshake values
    always @(posedge clk) begin
        if (rst || flush) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            stalled = outValid && !outReady;
            holdImm = outImm;
            holdTag = outTag;
            if (outValid && outReady && q.size() > 0) begin
                void'(q.pop_front());
                outCount++;
                if (outTag == 8'hEE) seenFlushed = 1'b1;
            end
            if (inValid && inReady) q.push_back(modelDecode(inInstr, 32, inTag));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 64'(outValid), 64'(q.size() != 0));
            chk("in_ready", 64'(inReady), 64'(q.size() < 2));
            if (outValid && q.size() > 0) begin
                chk("out_imm", 64'(outImm), 64'(q[0].imm[31:0]));
                chk("out_fmt", 64'(outFmt), 64'(q[0].fmt));
                chk("out_tag", 64'(outTag), 64'(q[0].tag));
                chk("out_illegal", 64'(outIll), 64'(q[0].ill));
            end
            if (stalled && outValid) begin
                chk("stall_imm_stable", 64'(outImm), 64'(holdImm));
                chk("stall_tag_stable", 64'(outTag), 64'(holdTag));
            end
            if (!inReady) sawBusy = 1'b1;
        end
    end

    task automatic sendWord(input logic [31:0] w, input logic [7:0] t);
        int n;
        n = 0;
        @(negedge clk);
        inValid = 1'b1;
        inInstr = w;
        inTag   = t;
        while (!inReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, tag 0x%0h", t);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic dirCheck(input logic [31:0] w, input logic [7:0] t,
                            input logic [31:0] expImm, input logic [2:0] expFmt, input logic expIll);
        sendWord(w, t);
        idle();
        chk("dir_valid", 64'(outValid), 64'd1);
        chk("dir_imm", 64'(outImm), 64'(expImm));
        chk("dir_fmt", 64'(outFmt), 64'(expFmt));
        chk("dir_ill", 64'(outIll), 64'(expIll));
        chk("dir_tag", 64'(outTag), 64'(t));
    endtask

    task automatic dir64(input logic [31:0] w, input logic [63:0] expImm,
                         input logic [2:0] expFmt, input logic expIll);
        exp_t m;
        m = modelDecode(w, 64, 8'h64);
        @(negedge clk);
        in64Valid = 1'b1;
        in64Instr = w;
        in64Tag   = 8'h64;
        @(posedge clk);
        @(negedge clk);
        in64Valid = 1'b0;
        chk("x64_valid", 64'(out64Valid), 64'd1);
        chk("x64_imm", out64Imm, expImm);
        chk("x64_imm_model", out64Imm, m.imm);
        chk("x64_fmt", 64'(out64Fmt), 64'(expFmt));
        chk("x64_ill", 64'(out64Ill), 64'(expIll));
    endtask

    initial begin
        logic [31:0] words [6];
        int startCount;
        words = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h4030D093, 32'h3002D073, 32'h0000007F};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(outValid), 64'd0);
        chk("rst_out_imm", 64'(outImm), 64'd0);
        chk("rst_out_fmt", 64'(outFmt), 64'd0);
        chk("rst_out_tag", 64'(outTag), 64'd0);
        chk("rst_out_ill", 64'(outIll), 64'd0);
        chk("rst_in_ready", 64'(inReady), 64'd1);
        rst = 1'b0;

        dirCheck(32'hFFF00093, 8'h41, 32'hFFFFFFFF, 3'd1, 1'b0);
        dirCheck(32'hFE000EE3, 8'h42, 32'hFFFFFFFC, 3'd3, 1'b0);
        dirCheck(32'h123450B7, 8'h43, 32'h12345000, 3'd4, 1'b0);
        dirCheck(32'h4030D093, 8'h44, 32'h00000003, 3'd6, 1'b0);
        if (ZIMM_ON) dirCheck(32'h3002D073, 8'h45, 32'h00000005, 3'd7, 1'b0);
        else         dirCheck(32'h3002D073, 8'h45, 32'h00000300, 3'd1, 1'b0);
        dirCheck(32'h0000007F, 8'h46, 32'h00000000, 3'd0, 1'b1);
        dirCheck(32'h0000009B, 8'h47, 32'h00000000, 3'd0, 1'b1);
        dirCheck(32'hFE112E23, 8'h48, 32'hFFFFFFFC, 3'd2, 1'b0);
        dirCheck(32'h0080006F, 8'h49, 32'h00000008, 3'd5, 1'b0);
        dirCheck(32'h002081B3, 8'h4A, 32'h00000000, 3'd0, 1'b0);

        // Six back-to-back words with the consumer stalled for three cycles
        @(negedge clk);
        startCount = outCount;
        sawBusy = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) sendWord(words[i], 8'(i + 1));
                idle();
            end
            begin
                for (int c = 1; c <= 8; c++) begin
                    @(negedge clk);
                    outReady = !(c >= 2 && c <= 4);
                end
                outReady = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        chk("stream_count", 64'(outCount - startCount), 64'd6);
        chk("stream_drained", 64'(q.size()), 64'd0);
        chk("stream_backpressure", 64'(sawBusy), 64'd1);

        // Fill both entries, then flush while presenting a word
        outReady = 1'b0;
        sendWord(32'h00100093, 8'h21);
        sendWord(32'h00200093, 8'h22);
        @(negedge clk);
        chk("full_in_ready", 64'(inReady), 64'd0);
        inValid = 1'b1;
        inInstr = 32'h00300093;
        inTag   = 8'hEE;
        flush   = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        inValid = 1'b0;
        chk("flush_out_valid", 64'(outValid), 64'd0);
        chk("flush_in_ready", 64'(inReady), 64'd1);
        outReady = 1'b1;
        repeat (4) @(negedge clk);
        chk("flush_word_absent", 64'(seenFlushed), 64'd0);

        // Reset with two entries buffered
        outReady = 1'b0;
        sendWord(32'hFFF00093, 8'h31);
        sendWord(32'h0080006F, 8'h32);
        @(negedge clk);
        inValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(outValid), 64'd0);
        chk("mid_rst_out_imm", 64'(outImm), 64'd0);
        chk("mid_rst_out_fmt", 64'(outFmt), 64'd0);
        chk("mid_rst_out_tag", 64'(outTag), 64'd0);
        chk("mid_rst_out_ill", 64'(outIll), 64'd0);
        chk("mid_rst_in_ready", 64'(inReady), 64'd1);
        rst = 1'b0;
        outReady = 1'b1;
        dirCheck(32'h123450B7, 8'h50, 32'h12345000, 3'd4, 1'b0);

        dir64(32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
        dir64(32'h02109093, 64'd33, 3'd6, 1'b0);
        dir64(32'h0230909B, 64'd3, 3'd6, 1'b0);
        dir64(32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        dir64(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
